// File: rtl/sfq_pkg.sv
// Shared definitions for the cycle-based SFQ cell library.
package sfq_pkg;

    // Modelled time per clock cycle, in picoseconds.
    localparam real SFQ_CYC_PS = 0.1;

    // Default interval-counter width for timing checks.
    localparam int SFQ_CNT_W = 8;

    // DRO cell default timing, in cycles.
    localparam int SFQ_DRO_DELAY_CYC = 50;
    localparam int SFQ_DRO_SETUP_CYC = 30;
    localparam int SFQ_DRO_HOLD_CYC  = 20;

    // Flux state of a storing cell.
    typedef enum logic {
        DRO_EMPTY  = 1'b0,
        DRO_LOADED = 1'b1
    } dro_state_e;

    // SFQ pulses are level toggles: any change from the previous sample is a pulse.
    function automatic logic sfq_pulse(input logic level, input logic level_q);
        return level ^ level_q;
    endfunction

endpackage

// File: rtl/sfq_delay_line.sv
// Fixed-latency pulse delay with toggle-encoded output.
// A launch bit sampled on edge N toggles toggle_o on edge N+DEPTH-1, so the new
// level is seen DEPTH cycles after the launching cycle. The output toggle flop
// is the last stage of the pipeline. Overlapping pulses are all preserved.
module sfq_delay_line #(
    parameter int DEPTH = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_i,
    output logic toggle_o
);

    logic tap;
    logic toggle_q;

    generate
        if (DEPTH == 1) begin : g_direct
            assign tap = pulse_i;
        end else begin : g_shift
            logic [DEPTH-2:0] shift_q;

            // Shift launch bits toward the output stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shift_q <= '0;
                end else begin
                    shift_q[0] <= pulse_i;
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        shift_q[i] <= shift_q[i-1];
                    end
                end
            end

            assign tap = shift_q[DEPTH-2];
        end
    endgenerate

    // Each bit leaving the shift stages flips the output level once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_q ^ tap;
        end
    end

    assign toggle_o = toggle_q;

endmodule

// File: rtl/dro_cell.sv
// RSFQ destructive-readout cell: stores one flux quantum on set, emits it on
// read after a fixed delay, and flags set/read setup and hold violations.
//
// state      | meaning
// -----------+----------------------------------------------
// DRO_EMPTY  | no flux stored; a read emits nothing
// DRO_LOADED | one flux quantum stored; a read emits a pulse
module dro_cell
    import sfq_pkg::*;
#(
    parameter int DELAY_CYC = SFQ_DRO_DELAY_CYC,
    parameter int SETUP_CYC = SFQ_DRO_SETUP_CYC,
    parameter int HOLD_CYC  = SFQ_DRO_HOLD_CYC,
    parameter int CNT_W     = SFQ_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic reset,
    output logic out,
    output logic setup_viol,
    output logic hold_viol,
    output logic stored
);

    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYC);

    logic             set_q;
    logic             reset_q;
    dro_state_e       state_q, state_d;
    // Flux state as it was just before the most recent set; a read that lands
    // inside the setup window is resolved against this instead of state_q.
    logic             pre_set_q, pre_set_d;
    logic [CNT_W-1:0] since_set_q, since_set_d;
    logic [CNT_W-1:0] since_rd_q, since_rd_d;
    logic             setup_viol_q;
    logic             hold_viol_q;

    logic set_p;
    logic rd_p;
    logic setup_hit;
    logic hold_hit;
    logic launch;

    assign set_p     = sfq_pulse(set, set_q);
    assign rd_p      = sfq_pulse(reset, reset_q);
    assign setup_hit = rd_p && (set_p || (since_set_q < SETUP_LIM));
    assign hold_hit  = set_p && (since_rd_q < HOLD_LIM);

    // Resolve the next flux state; a violating read is ordered before its set.
    always_comb begin
        state_d   = state_q;
        pre_set_d = pre_set_q;
        launch    = 1'b0;
        if (setup_hit) begin
            launch    = set_p ? (state_q == DRO_LOADED) : pre_set_q;
            pre_set_d = 1'b0;
            state_d   = DRO_LOADED;
        end else if (rd_p) begin
            launch    = (state_q == DRO_LOADED);
            state_d   = DRO_EMPTY;
        end else if (set_p) begin
            pre_set_d = (state_q == DRO_LOADED);
            state_d   = DRO_LOADED;
        end
    end

    // Saturating cycle counts since the last set and last read pulse.
    always_comb begin
        since_set_d = since_set_q;
        since_rd_d  = since_rd_q;
        if (set_p) begin
            since_set_d = CNT_W'(1);
        end else if (since_set_q != CNT_SAT) begin
            since_set_d = since_set_q + 1'b1;
        end
        if (rd_p) begin
            since_rd_d = CNT_W'(1);
        end else if (since_rd_q != CNT_SAT) begin
            since_rd_d = since_rd_q + 1'b1;
        end
    end

    // Cell state, edge-detect history, counters and registered violation strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q        <= 1'b0;
            reset_q      <= 1'b0;
            state_q      <= DRO_EMPTY;
            pre_set_q    <= 1'b0;
            since_set_q  <= CNT_SAT;
            since_rd_q   <= CNT_SAT;
            setup_viol_q <= 1'b0;
            hold_viol_q  <= 1'b0;
        end else begin
            set_q        <= set;
            reset_q      <= reset;
            state_q      <= state_d;
            pre_set_q    <= pre_set_d;
            since_set_q  <= since_set_d;
            since_rd_q   <= since_rd_d;
            setup_viol_q <= setup_hit;
            hold_viol_q  <= hold_hit;
        end
    end

    sfq_delay_line #(
        .DEPTH(DELAY_CYC)
    ) u_out_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_i (launch),
        .toggle_o(out)
    );

    assign stored     = (state_q == DRO_LOADED);
    assign setup_viol = setup_viol_q;
    assign hold_viol  = hold_viol_q;

endmodule

// File: tb/tb_dro_cell.sv
// Bench for dro_cell with default parameters: directed scenarios, a boundary
// table, and randomized pulses checked every cycle against an event-time model.
module tb_dro_cell;

    localparam int DELAY = 50;
    localparam int SETUP = 30;
    localparam int HOLD  = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_i = 1'b0;
    logic reset_i = 1'b0;
    logic out, setup_viol, hold_viol, stored;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    // Reference model: pulse timestamps and a queue of scheduled output toggles.
    bit m_out, m_stored, m_before_set, m_su, m_ho;
    bit m_prev_s, m_prev_r;
    int m_last_set, m_last_rd;
    int m_toggle_at[$];

    typedef struct {
        bit rd_first;
        int gap;
        bit exp_su;
        bit exp_ho;
        bit exp_stored;
    } bvec_t;

    bvec_t tbl[8];

    dro_cell dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       (set_i),
        .reset     (reset_i),
        .out       (out),
        .setup_viol(setup_viol),
        .hold_viol (hold_viol),
        .stored    (stored)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        m_out = 0; m_stored = 0; m_before_set = 0; m_su = 0; m_ho = 0;
        m_prev_s = 0; m_prev_r = 0;
        m_last_set = -100000; m_last_rd = -100000;
        m_toggle_at.delete();
    endtask

    // Apply the cell's rules to the sample taken on edge n.
    task automatic model_edge(input int n, input bit s, input bit r);
        bit sp, rp, fire;
        sp = (s != m_prev_s);
        rp = (r != m_prev_r);
        m_prev_s = s;
        m_prev_r = r;
        m_su = rp && (sp || (n - m_last_set < SETUP));
        m_ho = sp && (n - m_last_rd < HOLD);
        fire = 0;
        if (m_su) begin
            // read happens logically before the colliding set
            fire = sp ? m_stored : m_before_set;
            m_before_set = 0;
            m_stored = 1;
        end else if (rp) begin
            fire = m_stored;
            m_stored = 0;
        end else if (sp) begin
            m_before_set = m_stored;
            m_stored = 1;
        end
        if (sp) m_last_set = n;
        if (rp) m_last_rd = n;
        // new level visible DELAY cycles after the read cycle, i.e. after edge n+DELAY-1
        if (fire) m_toggle_at.push_back(n + DELAY - 1);
        while (m_toggle_at.size() > 0 && m_toggle_at[0] == n) begin
            m_out = ~m_out;
            void'(m_toggle_at.pop_front());
        end
    endtask

    // One clock: drive toggles, take the edge, compare all outputs, end at negedge.
    task automatic step(input bit ts, input bit tr);
        set_i = set_i ^ ts;
        reset_i = reset_i ^ tr;
        @(posedge clk);
        cyc++;
        model_edge(cyc, set_i, reset_i);
        #1;
        chk($sformatf("cyc%0d {out,stored,su,ho}", cyc),
            {out, stored, setup_viol, hold_viol},
            {m_out, m_stored, m_su, m_ho});
        @(negedge clk);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step(0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        set_i = 0;
        reset_i = 0;
        model_clear();
        #1;
        chk("reset_values", {out, stored, setup_viol, hold_viol}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        cyc = 0;
    endtask

    initial begin
        tbl[0] = '{rd_first: 0, gap: 29,  exp_su: 1, exp_ho: 0, exp_stored: 1};
        tbl[1] = '{rd_first: 0, gap: 30,  exp_su: 0, exp_ho: 0, exp_stored: 0};
        tbl[2] = '{rd_first: 0, gap: 1,   exp_su: 1, exp_ho: 0, exp_stored: 1};
        tbl[3] = '{rd_first: 0, gap: 255, exp_su: 0, exp_ho: 0, exp_stored: 0};
        tbl[4] = '{rd_first: 1, gap: 19,  exp_su: 0, exp_ho: 1, exp_stored: 1};
        tbl[5] = '{rd_first: 1, gap: 20,  exp_su: 0, exp_ho: 0, exp_stored: 1};
        tbl[6] = '{rd_first: 1, gap: 1,   exp_su: 0, exp_ho: 1, exp_stored: 1};
        tbl[7] = '{rd_first: 1, gap: 300, exp_su: 0, exp_ho: 0, exp_stored: 1};

        model_clear();
        @(negedge clk);
        do_reset();

        // Basic read
        run_to(99);  step(1, 0);
        chk("basic stored set", stored, 1);
        run_to(199); step(0, 1);
        chk("basic stored cleared", stored, 0);
        chk("basic no strobes", {setup_viol, hold_viol}, 0);
        run_to(248);
        chk("basic out before", out, 0);
        step(0, 0);
        chk("basic out at 250", out, 1);

        // Empty read
        do_reset();
        run_to(99);  step(0, 1);
        chk("empty no strobes", {setup_viol, hold_viol}, 0);
        run_to(170);
        chk("empty out", out, 0);
        chk("empty stored", stored, 0);

        // Setup violation, read consumes the earlier flux
        do_reset();
        run_to(99);  step(1, 0);
        run_to(199); step(1, 0);
        run_to(223); step(0, 1);
        chk("setup strobe at 225", setup_viol, 1);
        chk("setup stored", stored, 1);
        step(0, 0);
        chk("setup strobe one cycle", setup_viol, 0);
        run_to(272);
        chk("setup out before", out, 0);
        step(0, 0);
        chk("setup out at 274", out, 1);
        chk("setup stored after", stored, 1);

        // Simultaneous pulses on an empty cell
        do_reset();
        run_to(99);  step(1, 1);
        chk("simul setup strobe", setup_viol, 1);
        chk("simul hold strobe", hold_viol, 0);
        chk("simul stored", stored, 1);
        run_to(170);
        chk("simul out", out, 0);

        // Hold violation
        do_reset();
        run_to(99);  step(1, 0);
        run_to(199); step(0, 1);
        run_to(209); step(1, 0);
        chk("hold strobe at 211", hold_viol, 1);
        chk("hold no setup", setup_viol, 0);
        chk("hold stored", stored, 1);
        run_to(248);
        chk("hold out before", out, 0);
        step(0, 0);
        chk("hold out at 250", out, 1);

        // Reset while a pulse is in flight
        do_reset();
        run_to(99);  step(1, 0);
        run_to(199); step(0, 1);
        run_to(219);
        do_reset();
        run_to(80);
        chk("midreset out", out, 0);
        chk("midreset stored", stored, 0);

        // Pulse present on the first clock after release
        do_reset();
        step(1, 0);
        chk("first edge set", stored, 1);

        // Window boundaries
        foreach (tbl[k]) begin
            do_reset();
            run_to(9);
            if (tbl[k].rd_first) step(0, 1); else step(1, 0);
            run_to(9 + tbl[k].gap);
            if (tbl[k].rd_first) step(1, 0); else step(0, 1);
            chk($sformatf("tbl%0d setup", k), setup_viol, tbl[k].exp_su);
            chk($sformatf("tbl%0d hold", k), hold_viol, tbl[k].exp_ho);
            chk($sformatf("tbl%0d stored", k), stored, tbl[k].exp_stored);
            repeat (60) step(0, 0);
        end

        // Randomized pulse trains against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
        end
        repeat (60) step(0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
